// File: rtl/sram_responder_if.sv
// Base-RAM bus between a RAM controller (master) and a device (slave).
// The shared data bus resolves here, so each side has one driver plus an enable.
interface sram_responder_if #(
    parameter int unsigned DATA_W = 32
);
    logic [19:0]       baseram_addr;
    logic              baseram_ce;
    logic              baseram_oe;
    logic              baseram_we;
    logic [DATA_W-1:0] ctl_dq;
    logic              ctl_dq_oe;
    logic [DATA_W-1:0] dev_dq;
    logic              dev_dq_oe;
    wire  [DATA_W-1:0] baseram_data;

    // Device read drive wins; with neither side enabled the bus floats.
    assign baseram_data = dev_dq_oe ? dev_dq : (ctl_dq_oe ? ctl_dq : {DATA_W{1'bz}});

    modport master (
        output baseram_addr, baseram_ce, baseram_oe, baseram_we, ctl_dq, ctl_dq_oe,
        input  dev_dq_oe, baseram_data
    );

    modport slave (
        input  baseram_addr, baseram_ce, baseram_oe, baseram_we, baseram_data,
        output dev_dq, dev_dq_oe
    );
endinterface

// File: rtl/sram_responder.sv
// Clocked SRAM stand-in for the base-RAM bus: internal array, configurable
// read latency, saturating access counters and a sticky out-of-range flag.
module sram_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_responder_if.slave        bus,
    output logic [15:0]            wr_count,
    output logic [15:0]            rd_count,
    output logic                   addr_err,
    output logic                   busy
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned BADR_W = 20;
    localparam int unsigned CNT_W  = 16;
    localparam logic [1:0]  LAT_INIT = 2'(READ_LAT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_RWAIT  = 2'd2;
    localparam logic [1:0] S_RDRIVE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BADR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        lat_q, lat_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              mem_we;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_cond, rd_cond, rd_live;
    logic [ADDR_W-1:0] live_idx;
    logic [DATA_W-1:0] live_rdata;

    function automatic logic oob(input logic [BADR_W-1:0] a);
        return (a >> ADDR_W) != BADR_W'(0);
    endfunction

    assign wr_cond  = ~bus.baseram_ce & ~bus.baseram_we;
    assign rd_cond  = ~bus.baseram_ce & ~bus.baseram_oe & bus.baseram_we;
    assign rd_live  = rd_cond & ~rst;
    assign live_idx = bus.baseram_addr[ADDR_W-1:0];
    assign live_rdata = oob(bus.baseram_addr) ? DATA_W'(0) : mem[live_idx];

    // Next-state and bookkeeping.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_cond) begin
                    addr_d  = bus.baseram_addr;
                    wdata_d = bus.baseram_data;
                    state_d = S_WRITE;
                end else if (rd_cond) begin
                    addr_d = bus.baseram_addr;
                    if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (oob(bus.baseram_addr)) err_d = 1'b1;
                    if (LAT_INIT == 2'd0) begin
                        state_d = S_RDRIVE;
                    end else begin
                        lat_d   = LAT_INIT;
                        state_d = S_RWAIT;
                    end
                end
            end
            S_WRITE: begin
                if (wr_cond) begin
                    addr_d  = bus.baseram_addr;
                    wdata_d = bus.baseram_data;
                end else begin
                    // Commit on the edge that sees the strobe released.
                    if (oob(addr_q)) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (!rd_cond) begin
                    state_d = S_IDLE;
                end else if (lat_q <= 2'd1) begin
                    lat_d   = 2'd0;
                    state_d = S_RDRIVE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_RDRIVE: begin
                if (!rd_cond) begin
                    state_d = S_IDLE;
                end else if ((LAT_INIT == 2'd0) && oob(bus.baseram_addr)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Array is not reset; the registered read word tracks the latched address.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[ADDR_W-1:0]] <= wdata_q;
        rdata_q <= oob(addr_q) ? DATA_W'(0) : mem[addr_q[ADDR_W-1:0]];
    end

    assign bus.dev_dq_oe = (LAT_INIT == 2'd0) ? rd_live : (rd_live & (state_q == S_RDRIVE));
    assign bus.dev_dq    = (LAT_INIT == 2'd0) ? live_rdata : rdata_q;

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
    assign addr_err = err_q;
    assign busy     = busy_q;
endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable, clocked responder for the base-RAM bus. It sits at the device end of the interface: it receives the active-low chip-enable, output-enable and write-enable strobes plus the address from the RAM controller, stores data in an internal array, and drives the shared data bus on reads. It is used as an on-chip stand-in for the external SRAM in FPGA bring-up and as the bus-functional device in controller benches. It also keeps transaction counters and a sticky out-of-range flag for debug display.

## Interface
- ADDR_W, 8: implemented address bits; depth is 2^ADDR_W words.
- DATA_W, 32: data bus width.
- READ_LAT, 0: read latency in cycles. Legal values are 0, 1 and 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- baseram_addr  in  20  word address from the controller.
- baseram_data  inout  DATA_W  shared data bus.
- baseram_ce  in  1  chip enable, active low.
- baseram_oe  in  1  output enable, active low.
- baseram_we  in  1  write enable, active low.
- wr_count  out  16  committed writes; saturates at 0xFFFF.
- rd_count  out  16  read accesses started; saturates at 0xFFFF.
- addr_err  out  1  sticky flag; set when any access uses an address with bits [19:ADDR_W] nonzero.
- busy  out  1  high in every state other than IDLE.

## Operation
**States:** IDLE, WRITE, READ_WAIT, READ_DRIVE.

**Sampled conditions** (inputs sampled at each rising edge):
- wr_cond = ~ce & ~we.
- rd_cond = ~ce & ~oe & we.
- WE has priority: when ce, oe and we are all low, the access is a write and the bus is never driven.

**IDLE**
- On wr_cond: latch addr and data, go to WRITE.
- On rd_cond: latch addr, increment rd_count.
  - READ_LAT=0: go to READ_DRIVE.
  - Otherwise: load the latency counter with READ_LAT and go to READ_WAIT.

**WRITE**
- While wr_cond holds, re-latch addr and data each cycle; the last sample wins.
- At the first edge where wr_cond is false (we or ce returned high), commit the latched data to the array and increment wr_count. Return to IDLE.
- If the latched address is out of range, do not commit or increment wr_count, and set addr_err.

**READ_WAIT**
- Decrement the counter each cycle; go to READ_DRIVE when it expires.
- If rd_cond drops, go to IDLE with no drive.

**READ_DRIVE**
- Stay while rd_cond holds; return to IDLE when it drops.
- Data source:
  - READ_LAT=0: combinational from the live baseram_addr.
  - READ_LAT≥1: the registered word at the latched address.
- An out-of-range address reads as zero and sets addr_err.

**Bus drive**
- The tristate enable is drive_state & ~baseram_ce & ~baseram_oe & baseram_we, gated combinationally.
- The bus releases in the same cycle that OE or CE rises, so it never contends with the controller's write drive. It is Z at all other times.
- READ_LAT=0 exception: the enable is simply ~ce & ~oe & we, so a read is valid within the cycle OE falls.

## Timing
**Reset values**
- state=IDLE, wr_count=0, rd_count=0, addr_err=0, busy=0, bus Z.
- Array contents are not reset.

**Write**
- Commit happens at the edge that samples we high.
- The word is readable from the next cycle.
- Minimum write is one sampled cycle with we low.

**Read latency**
- READ_LAT=0: data is valid combinationally after ce and oe are low and addr is stable.
- READ_LAT=N: data is driven starting N cycles after the edge that first samples rd_cond.

**Address**
- The address is sampled on the IDLE→READ edge.
- Later address changes within the same read are ignored for READ_LAT≥1.
- For READ_LAT=0 the data follows the live address.

**Boundary behaviour**
- A read abandoned before its latency expires drives nothing, but still counts in rd_count.
- Back-to-back accesses: a new access can start at the edge after returning to IDLE. Leaving a state and starting a new access does not happen at the same edge.
- Reset mid-write: the pending write is discarded and the array is unchanged.
- Reset mid-read: the bus releases immediately.
- Counters saturate at 0xFFFF and do not wrap.

## Test plan
- Write 0x0000_0005 to addr 0x03 with one we-low cycle, then read with READ_LAT=0 → bus 0x0000_0005 in the oe-low cycle; wr_count=1, rd_count=1.
- READ_LAT=2, read addr 0x03 → bus Z for 2 cycles, then 0x0000_0005. Raise oe → bus Z in the same cycle.
- Assert ce, oe and we low together with data 0xA → treated as a write with bus never driven; a later read returns 0xA.
- Write to addr 0x00100 (out of range) → no commit, addr_err=1 and stays 1; reading it returns 0.
- Assert rst while we is low with data 0xF to addr 0x07 → no commit; old contents of 0x07 are readable after reset; counters=0.
- Perform 65,537 writes → wr_count holds at 0xFFFF.
